// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port memory between instruction fetch (IF) and load/store (LS).
// Latency : read response at handshake+MEM_LATENCY+1, write response at handshake+2; one transaction in flight.
// Backpr. : ready only in IDLE (and only on enabled cycles); LS priority, IF starvation guard under ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_we,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // WAIT counter only needs to hold MEM_LATENCY-2
    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0);
    localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_ls;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    logic w_starve;
    logic w_if_win;
    logic w_ls_win;
    logic w_grant_ok;
    logic w_if_hs;
    logic w_ls_hs;

`ifdef ARB_STARVE_GUARD_EN
    localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
    logic [WCNT_W-1:0] r_wcnt;

    // Count enabled cycles IF has waited without a grant, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (clk_enable) begin
            if (!if_valid || w_if_hs) begin
                r_wcnt <= '0;
            end else if (r_wcnt < WCNT_W'(STARVE_LIMIT)) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    assign w_starve = (r_wcnt >= WCNT_W'(STARVE_LIMIT));
`else
    assign w_starve = 1'b0;
`endif

    // LS wins ties unless IF has waited long enough to be forced through
    assign w_if_win   = if_valid && (!ls_valid || w_starve);
    assign w_ls_win   = ls_valid && !w_if_win;
    // No acceptance during reset or on a stalled cycle
    assign w_grant_ok = (r_state == S_IDLE) && clk_enable && !rst;
    assign if_ready   = w_grant_ok && w_if_win;
    assign ls_ready   = w_grant_ok && w_ls_win;
    assign w_if_hs    = if_valid && if_ready;
    assign w_ls_hs    = ls_valid && ls_ready;

    // Next state and state-decoded outputs
    always_comb begin
        w_next       = r_state;
        mem_we       = 1'b0;
        if_rsp_valid = 1'b0;
        ls_rsp_valid = 1'b0;
        if_rdata     = r_if_rdata;
        ls_rdata     = r_ls_rdata;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_if_hs || w_ls_hs) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_we = r_we;
                if (r_we || SINGLE_CYCLE) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
                if (r_owner_ls) begin
                    ls_rsp_valid = 1'b1;
                    ls_rdata     = r_we ? '0 : mem_rdata;
                end else begin
                    if_rsp_valid = 1'b1;
                    if_rdata     = mem_rdata;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // State register, request latch, wait counter and response data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_ls  <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else if (clk_enable) begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_ls_hs) begin
                        r_owner_ls  <= 1'b1;
                        r_we        <= ls_we;
                        r_mem_addr  <= ls_addr;
                        r_mem_wdata <= ls_wdata;
                    end else if (w_if_hs) begin
                        r_owner_ls <= 1'b0;
                        r_we       <= 1'b0;
                        r_mem_addr <= if_addr;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_LOAD;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_RESP: begin
                    if (r_owner_ls) begin
                        r_ls_rdata <= r_we ? '0 : mem_rdata;
                    end else begin
                        r_if_rdata <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed bench for mem_port_arbiter (latency-1 instance a, latency-3 instance b).
// Latency : n/a.
// Backpr. : n/a.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ls_valid = 1'b0;
    logic [31:0] ls_addr = '0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        a_if_ready, a_if_rsp_valid, a_ls_ready, a_ls_rsp_valid, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;
    logic        b_if_ready, b_if_rsp_valid, b_ls_ready, b_ls_rsp_valid, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .if_valid(if_valid), .if_ready(a_if_ready), .if_addr(if_addr),
        .if_rsp_valid(a_if_rsp_valid), .if_rdata(a_if_rdata),
        .ls_valid(ls_valid), .ls_ready(a_ls_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wdata(ls_wdata),
        .ls_rsp_valid(a_ls_rsp_valid), .ls_rdata(a_ls_rdata),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .if_valid(if_valid), .if_ready(b_if_ready), .if_addr(if_addr),
        .if_rsp_valid(b_if_rsp_valid), .if_rdata(b_if_rdata),
        .ls_valid(ls_valid), .ls_ready(b_ls_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wdata(ls_wdata),
        .ls_rsp_valid(b_ls_rsp_valid), .ls_rdata(b_ls_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .busy(b_busy)
    );

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0; ls_valid = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; clk_enable = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_valid = 1'b1; ls_valid = 1'b1; ls_addr = 32'h44;
        tick();
        @(negedge clk);
        n_tests++; if (a_ls_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ls_ready: got %b want 0", a_ls_ready); end
        n_tests++; if (a_if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready: got %b want 0", a_if_ready); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        n_tests++; if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", a_mem_we); end
        n_tests++; if (a_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", a_mem_addr); end
        n_tests++; if (a_ls_rdata !== 32'h0 || a_if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", a_ls_rdata, a_if_rdata); end
        apply_reset();
    endtask

    task automatic test_ls_read();
        ls_valid = 1'b1; ls_addr = 32'h100; ls_we = 1'b0; mem_rdata = 32'h12345678;
        @(negedge clk);
        n_tests++; if (a_ls_ready !== 1'b1) begin n_fail++; $display("FAIL rd_t0_ls_ready: got %b want 1", a_ls_ready); end
        tick(); ls_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (a_mem_addr !== 32'h100 || a_mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_t1_mem: got addr %h we %b want 100/0", a_mem_addr, a_mem_we); end
        n_tests++; if (a_busy !== 1'b1 || a_ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_t1_busy_rsp: got %b/%b want 1/0", a_busy, a_ls_rsp_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (a_ls_rsp_valid !== 1'b1 || a_ls_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_t2_rsp: got %b %h want 1 12345678", a_ls_rsp_valid, a_ls_rdata); end
        n_tests++; if (a_if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_t2_if_rsp: got %b want 0", a_if_rsp_valid); end
        tick(); mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        n_tests++; if (a_ls_rsp_valid !== 1'b0 || a_ls_rdata !== 32'h12345678 || a_busy !== 1'b0) begin n_fail++; $display("FAIL rd_t3_hold: got %b %h %b want 0 12345678 0", a_ls_rsp_valid, a_ls_rdata, a_busy); end
        apply_reset();
    endtask

    task automatic test_both_valid();
        if_valid = 1'b1; if_addr = 32'h0; ls_valid = 1'b1; ls_addr = 32'h40; ls_we = 1'b0;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_tests++; if (a_ls_ready !== 1'b1 || a_if_ready !== 1'b0) begin n_fail++; $display("FAIL both_t0_ready: got ls %b if %b want 1/0", a_ls_ready, a_if_ready); end
        tick(); ls_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (a_mem_addr !== 32'h40 || a_if_ready !== 1'b0) begin n_fail++; $display("FAIL both_t1: got addr %h if_ready %b want 40/0", a_mem_addr, a_if_ready); end
        tick();
        @(negedge clk);
        n_tests++; if (a_ls_rsp_valid !== 1'b1 || a_if_ready !== 1'b0) begin n_fail++; $display("FAIL both_t2: got ls_rsp %b if_ready %b want 1/0", a_ls_rsp_valid, a_if_ready); end
        tick();
        @(negedge clk);
        n_tests++; if (a_if_ready !== 1'b1) begin n_fail++; $display("FAIL both_t3_if_ready: got %b want 1", a_if_ready); end
        tick(); if_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (a_mem_addr !== 32'h0 || a_if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL both_t4: got addr %h rsp %b want 0/0", a_mem_addr, a_if_rsp_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (a_if_rsp_valid !== 1'b1 || a_if_rdata !== 32'hCAFEF00D || a_ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL both_t5_if_rsp: got %b %h ls %b want 1 cafef00d 0", a_if_rsp_valid, a_if_rdata, a_ls_rsp_valid); end
        apply_reset();
    endtask

    task automatic test_starvation();
        logic exp_ls, exp_if;
        if_valid = 1'b1; if_addr = 32'h8; ls_valid = 1'b1; ls_addr = 32'h20; ls_we = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        for (int t = 0; t <= 6; t++) begin
            exp_ls = (t == 0) || (t == 3);
            exp_if = (t == 6);
            @(negedge clk);
            n_tests++; if (a_ls_ready !== exp_ls || a_if_ready !== exp_if) begin n_fail++; $display("FAIL starve_guard_t%0d: got ls %b if %b want %b/%b", t, a_ls_ready, a_if_ready, exp_ls, exp_if); end
            tick();
        end
`else
        for (int t = 0; t < 30; t++) begin
            exp_ls = ((t % 3) == 0);
            exp_if = 1'b0;
            @(negedge clk);
            n_tests++; if (a_ls_ready !== exp_ls || a_if_ready !== exp_if) begin n_fail++; $display("FAIL starve_strict_t%0d: got ls %b if %b want %b/%b", t, a_ls_ready, a_if_ready, exp_ls, exp_if); end
            tick();
        end
`endif
        apply_reset();
    endtask

    task automatic test_ls_write();
        ls_valid = 1'b1; ls_addr = 32'h80; ls_we = 1'b1; ls_wdata = 32'hDEADBEEF; mem_rdata = 32'h77777777;
        @(negedge clk);
        n_tests++; if (a_ls_ready !== 1'b1 || a_mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_t0: got ready %b we %b want 1/0", a_ls_ready, a_mem_we); end
        tick(); ls_valid = 1'b0; ls_we = 1'b0; ls_wdata = 32'h0;
        @(negedge clk);
        n_tests++; if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h80 || a_mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_t1: got we %b addr %h wdata %h want 1 80 deadbeef", a_mem_we, a_mem_addr, a_mem_wdata); end
        tick();
        @(negedge clk);
        n_tests++; if (a_mem_we !== 1'b0 || a_ls_rsp_valid !== 1'b1 || a_ls_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_t2: got we %b rsp %b rdata %h want 0 1 0", a_mem_we, a_ls_rsp_valid, a_ls_rdata); end
        tick();
        @(negedge clk);
        n_tests++; if (a_mem_we !== 1'b0 || a_mem_wdata !== 32'hDEADBEEF || a_ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_t3_hold: got we %b wdata %h rsp %b want 0 deadbeef 0", a_mem_we, a_mem_wdata, a_ls_rsp_valid); end
        apply_reset();
    endtask

    task automatic test_clk_enable();
        // enabled on even cycles only; handshake c0, ISSUE through c2, RESP through c4
        logic exp_rsp, exp_busy;
        ls_valid = 1'b1; ls_addr = 32'h200; ls_we = 1'b0; mem_rdata = 32'h55AA55AA;
        for (int c = 0; c <= 5; c++) begin
            clk_enable = ((c % 2) == 0);
            if (c > 0) ls_valid = 1'b0;
            exp_rsp  = (c == 3) || (c == 4);
            exp_busy = (c >= 1) && (c <= 4);
            @(negedge clk);
            if (c == 0) begin
                n_tests++; if (a_ls_ready !== 1'b1) begin n_fail++; $display("FAIL ce_c0_ready: got %b want 1", a_ls_ready); end
            end else begin
                n_tests++; if (a_ls_rsp_valid !== exp_rsp || a_busy !== exp_busy) begin n_fail++; $display("FAIL ce_c%0d: got rsp %b busy %b want %b/%b", c, a_ls_rsp_valid, a_busy, exp_rsp, exp_busy); end
            end
            if (c == 1 || c == 2) begin
                n_tests++; if (a_mem_addr !== 32'h200) begin n_fail++; $display("FAIL ce_c%0d_addr: got %h want 200", c, a_mem_addr); end
            end
            if (c >= 3) begin
                n_tests++; if (a_ls_rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL ce_c%0d_rdata: got %h want 55aa55aa", c, a_ls_rdata); end
            end
            tick();
        end
        apply_reset();
    endtask

    task automatic test_reset_in_wait();
        ls_valid = 1'b1; ls_addr = 32'h300; ls_we = 1'b0; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        n_tests++; if (b_ls_ready !== 1'b1) begin n_fail++; $display("FAIL rw_t0_ready: got %b want 1", b_ls_ready); end
        tick(); ls_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (b_mem_addr !== 32'h300 || b_busy !== 1'b1) begin n_fail++; $display("FAIL rw_t1: got addr %h busy %b want 300/1", b_mem_addr, b_busy); end
        tick();
        #2;
        n_tests++; if (b_busy !== 1'b1 || b_ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_t2_wait: got busy %b rsp %b want 1/0", b_busy, b_ls_rsp_valid); end
        rst = 1'b1;
        #1;
        n_tests++; if (b_busy !== 1'b0 || b_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_async_rst: got busy %b addr %h want 0/0", b_busy, b_mem_addr); end
        tick();
        rst = 1'b0;
        ls_valid = 1'b1; ls_addr = 32'h304; mem_rdata = 32'h13572468;
        @(negedge clk);
        n_tests++; if (b_ls_ready !== 1'b1) begin n_fail++; $display("FAIL rw_regrant: got %b want 1", b_ls_ready); end
        tick(); ls_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_tests++; if (b_ls_rsp_valid !== (k == 4) || b_if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_post_k%0d: got ls_rsp %b if_rsp %b want %b/0", k, b_ls_rsp_valid, b_if_rsp_valid, (k == 4)); end
            if (k == 4) begin
                n_tests++; if (b_ls_rdata !== 32'h13572468) begin n_fail++; $display("FAIL rw_rdata: got %h want 13572468", b_ls_rdata); end
            end
            tick();
        end
        apply_reset();
    endtask

    initial begin
        #1;
        test_reset();
        test_ls_read();
        test_both_valid();
        test_starvation();
        test_ls_write();
        test_clk_enable();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
